// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register offsets, STATUS bit
// positions and the transmit FSM state type.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;

  localparam int STATUS_FULL      = 0;
  localparam int STATUS_EMPTY     = 1;
  localparam int STATUS_BUSY      = 2;
  localparam int STATUS_OVERFLOW  = 3;
  localparam int STATUS_COUNT_LSB = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  // A programmed divisor of zero would stall the baud counter, so it runs as one.
  function automatic logic [15:0] effectiveDiv(input logic [15:0] raw);
    return (raw == 16'd0) ? 16'd1 : raw;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; reusable for TX and RX.
// Pushes into a full FIFO are dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         popData_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     pushDropped_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full_o        = (count_q == CW'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign popData_o     = mem_q[rdPtr_q];
  assign doPop         = pop_i && !empty_o;
  assign doPush        = push_i && (!full_o || doPop);
  assign pushDropped_o = push_i && !doPush;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter
// and a registered serial output. Loads return status in the same cycle.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic [3:0]  write_mask_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] d_write_i,
  output logic [31:0] d_read_o,
  output logic        tx_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bitIdx_q, bitIdx_d;
  logic [15:0]    baudCnt_q, baudCnt_d;
  logic [15:0]    div_q, div_d;
  logic [15:0]    baudDiv_q, baudDiv_d;
  logic           overflow_q, overflow_d;
  logic           tx_q, tx_d;

  logic [1:0]     regSel;
  logic           pushReq, fifoPop, fifoFull, fifoEmpty, pushDropped, busy;
  logic [7:0]     fifoData;
  logic [CW-1:0]  fifoCount;
  logic [31:0]    statusWord;
  logic           unusedBits;

  assign regSel     = addr_i[3:2];
  assign pushReq    = sel_i && write_mask_i[0] && (regSel == REG_TXDATA);
  assign unusedBits = ^{addr_i[31:4], addr_i[1:0], d_write_i[31:16]};
  assign tx_o       = tx_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txFifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (pushReq),
    .pushData_i   (d_write_i[7:0]),
    .pop_i        (fifoPop),
    .popData_o    (fifoData),
    .full_o       (fifoFull),
    .empty_o      (fifoEmpty),
    .count_o      (fifoCount),
    .pushDropped_o(pushDropped)
  );

  // Register writes; TXDATA pushes and STATUS clears never coincide, so overflow set/clear cannot conflict.
  always_comb begin
    baudDiv_d  = baudDiv_q;
    overflow_d = overflow_q || pushDropped;
    if (sel_i && (regSel == REG_BAUD_DIV)) begin
      if (write_mask_i[0]) baudDiv_d[7:0]  = d_write_i[7:0];
      if (write_mask_i[1]) baudDiv_d[15:8] = d_write_i[15:8];
    end
    if (sel_i && write_mask_i[0] && (regSel == REG_STATUS) && d_write_i[STATUS_OVERFLOW])
      overflow_d = 1'b0;
  end

  always_comb begin
    statusWord                             = '0;
    statusWord[STATUS_FULL]                = fifoFull;
    statusWord[STATUS_EMPTY]               = fifoEmpty;
    statusWord[STATUS_BUSY]                = busy;
    statusWord[STATUS_OVERFLOW]            = overflow_q;
    statusWord[STATUS_COUNT_LSB +: 4]      = 4'(fifoCount);
    d_read_o = '0;
    if (sel_i && (write_mask_i == 4'b0000)) begin
      case (regSel)
        REG_STATUS:   d_read_o = statusWord;
        REG_BAUD_DIV: d_read_o = {16'd0, baudDiv_q};
        default:      d_read_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitIdx_q   <= '0;
      baudCnt_q  <= '0;
      div_q      <= '0;
      baudDiv_q  <= 16'(CLKS_PER_BIT);
      overflow_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitIdx_q   <= bitIdx_d;
      baudCnt_q  <= baudCnt_d;
      div_q      <= div_d;
      baudDiv_q  <= baudDiv_d;
      overflow_q <= overflow_d;
      tx_q       <= tx_d;
    end
  end

  // The divisor is captured at frame start so BAUD_DIV writes only affect later frames.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitIdx_d  = bitIdx_q;
    baudCnt_d = baudCnt_q;
    div_d     = div_q;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          shift_d   = fifoData;
          div_d     = effectiveDiv(baudDiv_q);
          baudCnt_d = div_d - 16'd1;
          state_d   = START;
        end
      end
      START: begin
        if (baudCnt_q == 16'd0) begin
          state_d   = DATA;
          bitIdx_d  = 3'd0;
          baudCnt_d = div_q - 16'd1;
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      DATA: begin
        if (baudCnt_q == 16'd0) begin
          shift_d   = {1'b0, shift_q[7:1]};
          baudCnt_d = div_q - 16'd1;
          if (bitIdx_q == 3'd7) state_d = STOP;
          else                  bitIdx_d = bitIdx_q + 3'd1;
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      STOP: begin
        if (baudCnt_q == 16'd0) state_d = IDLE;
        else                    baudCnt_d = baudCnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is derived from the next state so the registered line changes exactly at bit boundaries.
  always_comb begin
    fifoPop = (state_q == IDLE) && !fifoEmpty;
    busy    = (state_q != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed register/FIFO scenarios plus
// random bursts, with a line monitor decoding frames against a byte queue.
module tb_uart_tx_mmio;

  localparam int CLKS = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sel_i = 1'b0;
  logic [3:0]  write_mask_i = 4'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] d_write_i = 32'h0;
  logic [31:0] d_read_o;
  logic        tx_o;

  uart_tx_mmio #(.FIFO_DEPTH(8), .CLKS_PER_BIT(CLKS)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sel_i       (sel_i),
    .write_mask_i(write_mask_i),
    .addr_i      (addr_i),
    .d_write_i   (d_write_i),
    .d_read_o    (d_read_o),
    .tx_o        (tx_o)
  );

  always #10 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model: bytes expected on the line in order, and the programmed divisor.
  logic [7:0]  expQ[$];
  logic [15:0] baudModel = 16'(CLKS);
  int          startLog[$];
  int          frameCount = 0;

  // Line monitor state
  logic        inFrame = 1'b0;
  int          frameDiv = 1;
  int          samp = 0;
  int          bitPos = 0;
  logic [9:0]  frameBits = '0;
  logic        stable = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // One bus cycle; read data is sampled late in the cycle, before the edge.
  task automatic applyStimulus(input logic s, input logic [3:0] m, input logic [31:0] a,
                               input logic [31:0] w, output logic [31:0] r);
    sel_i = s;
    write_mask_i = m;
    addr_i = a;
    d_write_i = w;
    #8 r = d_read_o;
    @(posedge clk_i);
    #1;
    if (s && (a[3:2] == 2'd2)) begin
      if (m[0]) baudModel[7:0]  = w[7:0];
      if (m[1]) baudModel[15:8] = w[15:8];
    end
    sel_i = 1'b0;
    write_mask_i = 4'b0;
    addr_i = 32'h0;
    d_write_i = 32'h0;
  endtask

  task automatic finishFrame();
    logic [7:0] e;
    checkOutput("frame expected", 32'(expQ.size() != 0), 32'd1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("frame bits", 32'(frameBits), 32'({1'b1, e, 1'b0}));
    end
    checkOutput("bit timing", 32'(stable), 32'd1);
  endtask

  task automatic monitorStep();
    if (rst_i) begin
      inFrame = 1'b0;
      expQ.delete();
    end else begin
      if (!inFrame && (tx_o === 1'b0)) begin
        inFrame   = 1'b1;
        frameDiv  = (baudModel == 16'd0) ? 1 : int'(baudModel);
        samp      = 0;
        bitPos    = 0;
        stable    = 1'b1;
        frameBits = '0;
        startLog.push_back(cyc);
      end
      if (inFrame) begin
        if (samp == 0) frameBits[bitPos] = tx_o;
        else if (tx_o !== frameBits[bitPos]) stable = 1'b0;
        samp++;
        if (samp == frameDiv) begin
          samp = 0;
          bitPos++;
          if (bitPos == 10) begin
            inFrame = 1'b0;
            frameCount++;
            finishFrame();
          end
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk_i);
    monitorStep();
  end

  task automatic waitFrames(input int target, input int budget, input string tag);
    int n = 0;
    while (frameCount < target && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 32'(frameCount), 32'(target));
    tick(2);
  endtask

  task automatic pushByte(input logic [7:0] b, input logic expect_accept);
    logic [31:0] r;
    applyStimulus(1'b1, 4'b0001, 32'h1000_0000, {24'h0, b}, r);
    if (expect_accept) expQ.push_back(b);
  endtask

  initial begin
    logic [31:0] r;
    int base;
    int fc;
    int n;

    // Reset and register access
    tick(2);
    checkOutput("reset tx", 32'(tx_o), 32'd1);
    rst_i = 1'b0;
    applyStimulus(1'b1, 4'b0000, 32'h1000_0004, 32'h0, r);
    checkOutput("reset status", r, 32'h0000_0002);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0008, 32'h0, r);
    checkOutput("reset baud", r, 32'd4);
    applyStimulus(1'b1, 4'b0010, 32'h1000_0008, 32'h0000_0300, r);
    checkOutput("read during write", r, 32'h0);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0008, 32'h0, r);
    checkOutput("baud lane1", r, 32'h0000_0304);
    applyStimulus(1'b1, 4'b0001, 32'h1000_0008, 32'h0000_0002, r);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0008, 32'h0, r);
    checkOutput("baud lane0", r, 32'h0000_0302);
    applyStimulus(1'b1, 4'b0011, 32'h1000_0008, 32'd4, r);
    applyStimulus(1'b1, 4'b1100, 32'h1000_0008, 32'hFFFF_FFFF, r);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0008, 32'h0, r);
    checkOutput("baud upper lanes", r, 32'd4);

    // Single frame of 0xA5
    fc = frameCount;
    pushByte(8'hA5, 1'b1);
    tick(5);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0004, 32'h0, r);
    checkOutput("busy status", r, 32'h0000_0006);
    waitFrames(fc + 1, 100, "a5 frame done");
    applyStimulus(1'b1, 4'b0000, 32'h1000_0004, 32'h0, r);
    checkOutput("status after a5", r, 32'h0000_0002);

    // Fill to full, overflow, clear
    fc = frameCount;
    base = startLog.size();
    for (int i = 0; i < 9; i++) pushByte(8'h10 + 8'(i), 1'b1);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0004, 32'h0, r);
    checkOutput("full status", r, 32'h0000_0085);
    pushByte(8'hEE, 1'b0);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0004, 32'h0, r);
    checkOutput("overflow status", r, 32'h0000_008D);
    applyStimulus(1'b1, 4'b0001, 32'h1000_0004, 32'h0000_0008, r);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0004, 32'h0, r);
    checkOutput("overflow cleared", r, 32'h0000_0085);
    waitFrames(fc + 9, 9 * 41 + 60, "burst9 done");
    if (startLog.size() >= base + 2)
      checkOutput("frame gap div4", 32'(startLog[base+1] - startLog[base]), 32'd41);
    else
      checkOutput("frame gap div4 logged", 32'(startLog.size()), 32'(base + 2));
    applyStimulus(1'b1, 4'b0000, 32'h1000_0004, 32'h0, r);
    checkOutput("status after burst", r, 32'h0000_0002);

    // Mid-frame divisor change
    fc = frameCount;
    base = startLog.size();
    pushByte(8'hC3, 1'b1);
    pushByte(8'h3C, 1'b1);
    pushByte(8'h96, 1'b1);
    tick(10);
    applyStimulus(1'b1, 4'b0011, 32'h1000_0008, 32'd2, r);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0008, 32'h0, r);
    checkOutput("baud readback 2", r, 32'd2);
    waitFrames(fc + 3, 200, "div change frames");
    if (startLog.size() >= base + 3) begin
      checkOutput("gap old div", 32'(startLog[base+1] - startLog[base]), 32'd41);
      checkOutput("gap new div", 32'(startLog[base+2] - startLog[base+1]), 32'd21);
    end else begin
      checkOutput("div change logged", 32'(startLog.size()), 32'(base + 3));
    end

    // Reset during DATA bit 3
    applyStimulus(1'b1, 4'b0011, 32'h1000_0008, 32'd4, r);
    pushByte(8'h81, 1'b1);
    n = 0;
    while (!inFrame && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput("frame started", 32'(inFrame), 32'd1);
    pushByte(8'h42, 1'b1);
    pushByte(8'h24, 1'b1);
    tick(14);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    baudModel = 16'(CLKS);
    checkOutput("tx after reset", 32'(tx_o), 32'd1);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0004, 32'h0, r);
    checkOutput("status after reset", r, 32'h0000_0002);
    fc = frameCount;
    tick(100);
    checkOutput("no frame after reset", 32'(frameCount), 32'(fc));

    // Non-pushing writes and gated reads
    fc = frameCount;
    applyStimulus(1'b1, 4'b0010, 32'h1000_0000, 32'h0000_5555, r);
    applyStimulus(1'b1, 4'b0000, 32'h1000_0000, 32'h0000_00AA, r);
    checkOutput("txdata read", r, 32'h0);
    tick(20);
    checkOutput("no push lane1", 32'(frameCount), 32'(fc));
    applyStimulus(1'b1, 4'b0000, 32'h1000_0004, 32'h0, r);
    checkOutput("status no push", r, 32'h0000_0002);
    applyStimulus(1'b0, 4'b0000, 32'h1000_0004, 32'h0, r);
    checkOutput("sel low read", r, 32'h0);
    applyStimulus(1'b1, 4'b0000, 32'h1000_000C, 32'h0, r);
    checkOutput("reserved read", r, 32'h0);

    // Random bursts with random divisors
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 4'b0011, 32'h1000_0008, 32'($urandom_range(0, 5)), r);
      n = $urandom_range(1, 8);
      fc = frameCount;
      for (int i = 0; i < n; i++) begin
        pushByte(8'($urandom), 1'b1);
        tick($urandom_range(0, 3));
      end
      waitFrames(fc + n, n * 51 + 60, "random burst done");
      applyStimulus(1'b1, 4'b0000, 32'h1000_0004, 32'h0, r);
      checkOutput("random status idle", r, 32'h0000_0002);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
